// File: rtl/led_pwm_apb.sv
// led_pwm_apb: APB3 slave driving four LEDs with double-buffered 8-bit PWM duty cycles.
// Define LED_PWM_BREATHE_EN to add the per-channel breathe ramp register at 0x10.
module led_pwm_apb #(
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd99
) (
    input  logic        io_systemClk,
    input  logic        io_asyncResetn,
    input  logic [4:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [3:0]  leds
);
`ifdef LED_PWM_BREATHE_EN
    localparam logic [2:0] LAST_WORD = 3'd4;
`else
    localparam logic [2:0] LAST_WORD = 3'd3;
`endif
    logic [4:0]  ctrl;
    logic [15:0] prescale;
    logic [15:0] pre_cnt;
    logic [31:0] duty;
    logic [7:0]  cnt;
    logic        wrap_flag;
    logic [7:0]  duty_act [4];
    logic [7:0]  duty_src [4];
    logic [31:0] rdata;
    logic [2:0]  word;
    logic        access, err_addr, wr, rd, en, tick, wrap;
    logic        unused;

    assign unused   = &{1'b0, PADDR[1:0]};
    assign word     = PADDR[4:2];
    assign err_addr = word > LAST_WORD;
    assign access   = PSEL & PENABLE;
    assign wr       = access & PWRITE & ~err_addr;
    assign rd       = access & ~PWRITE & ~err_addr;
    assign PSLVERR  = access & err_addr;
    assign PREADY   = 1'b1;
    assign PRDATA   = rd ? rdata : 32'd0;
    assign en       = ctrl[0];
    assign tick     = en && pre_cnt >= prescale;
    assign wrap     = tick && cnt == 8'hFF;

`ifdef LED_PWM_BREATHE_EN
    logic [3:0] breathe;
    logic [3:0] up;
    logic [7:0] lvl      [4];
    logic [7:0] lvl_next [4];

    always_comb begin
        rdata = (word == 3'd0) ? {27'd0, ctrl} :
                (word == 3'd1) ? {16'd0, prescale} :
                (word == 3'd2) ? duty :
                (word == 3'd3) ? {23'd0, wrap_flag, cnt} : {28'd0, breathe};
        for (int ch = 0; ch < 4; ch++) begin
            lvl_next[ch] = up[ch] ? lvl[ch] + 8'd1 : lvl[ch] - 8'd1;
            duty_src[ch] = !breathe[ch] ? duty[8*ch +: 8] : en ? lvl_next[ch] : 8'd0;
        end
    end

    // Ramp turns around on reaching either end so each extreme lasts one period.
    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            breathe <= '0;
            up      <= '1;
            for (int ch = 0; ch < 4; ch++) lvl[ch] <= '0;
        end else begin
            if (wr && word == 3'd4) breathe <= PWDATA[3:0];
            for (int ch = 0; ch < 4; ch++) begin
                if (!en) begin
                    lvl[ch] <= '0;
                    up[ch]  <= 1'b1;
                end else if (wrap && breathe[ch]) begin
                    lvl[ch] <= lvl_next[ch];
                    if (up[ch] && lvl_next[ch] == 8'hFF) up[ch] <= 1'b0;
                    else if (!up[ch] && lvl_next[ch] == 8'h00) up[ch] <= 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        rdata = (word == 3'd0) ? {27'd0, ctrl} :
                (word == 3'd1) ? {16'd0, prescale} :
                (word == 3'd2) ? duty : {23'd0, wrap_flag, cnt};
        for (int ch = 0; ch < 4; ch++) duty_src[ch] = duty[8*ch +: 8];
    end
`endif

    // Set of WRAP has priority over a same-edge write-1-to-clear.
    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            ctrl      <= '0;
            prescale  <= DEFAULT_PRESCALE;
            duty      <= '0;
            wrap_flag <= 1'b0;
            pre_cnt   <= '0;
            cnt       <= '0;
            leds      <= '0;
            for (int ch = 0; ch < 4; ch++) duty_act[ch] <= '0;
        end else begin
            if (wr && word == 3'd0) ctrl <= PWDATA[4:0];
            if (wr && word == 3'd1) prescale <= PWDATA[15:0];
            if (wr && word == 3'd2) duty <= PWDATA;
            if (wrap) wrap_flag <= 1'b1;
            else if (wr && word == 3'd3 && PWDATA[8]) wrap_flag <= 1'b0;
            pre_cnt <= (!en || tick) ? 16'd0 : pre_cnt + 16'd1;
            cnt     <= !en ? 8'd0 : tick ? cnt + 8'd1 : cnt;
            for (int ch = 0; ch < 4; ch++) begin
                if (!en || wrap) duty_act[ch] <= duty_src[ch];
                leds[ch] <= (en && cnt < duty_act[ch]) ^ ctrl[ch+1];
            end
        end
    end
endmodule
